pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard controller for a 5-stage pipeline.
// Handles taken branches in MEM, load-use stalls in ID, and data-memory wait
// holds, with a sticky fault when memory stays busy too long. All state
// changes on the falling clock edge, like the pipeline registers.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating stall/flush counters;
// without it both counter outputs are constant zero.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             pc_src,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

    logic [1:0] state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;

    logic branch_taken;
    logic load_use;

    // Unqualified control values, before the reset override
    logic pc_write_c, ifid_write_c, ifid_flush_c, idex_flush_c, exmem_flush_c;
    logic idex_hold_c, exmem_hold_c, pc_src_c;

    assign branch_taken = exmem_branch & exmem_zero;
    // Register 0 is hardwired, so a load "to r0" never creates a dependency
    assign load_use = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == id_rs) || (idex_rt == id_rt));

    // Mealy control: outputs and next state from current state and inputs
    always_comb begin
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;
        idex_hold_c   = 1'b0;
        exmem_hold_c  = 1'b0;
        pc_src_c      = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_err_d     = mem_err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    // Memory wait outranks everything: freeze the front of the pipe
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    idex_hold_c  = 1'b1;
                    exmem_hold_c = 1'b1;
                    wait_cnt_d   = 8'd1;
                    state_d      = ST_HOLD;
                end else if (branch_taken) begin
                    // The flush also squashes any load-use victim, so no stall is needed
                    pc_src_c      = 1'b1;
                    ifid_flush_c  = 1'b1;
                    idex_flush_c  = 1'b1;
                    exmem_flush_c = 1'b1;
                end else if (load_use) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    idex_flush_c = 1'b1;
                end
            end
            ST_HOLD: begin
                if (mem_busy) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    idex_hold_c  = 1'b1;
                    exmem_hold_c = 1'b1;
                    if (wait_cnt_q == TIMEOUT_VAL) begin
                        mem_err_d = 1'b1;
                        state_d   = ST_ERR;
                    end else if (wait_cnt_q != 8'hFF) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    // Release cycle drives idle values; hazards re-evaluate next cycle
                    state_d = ST_RUN;
                end
            end
            ST_ERR: begin
                pc_write_c   = 1'b0;
                ifid_write_c = 1'b0;
                idex_hold_c  = 1'b1;
                exmem_hold_c = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Control state, wait counter and sticky fault flag
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // While reset is low the pipeline must see idle controls regardless of inputs
    assign pc_write    = rst_n ? pc_write_c    : 1'b1;
    assign ifid_write  = rst_n ? ifid_write_c  : 1'b1;
    assign ifid_flush  = rst_n & ifid_flush_c;
    assign idex_flush  = rst_n & idex_flush_c;
    assign exmem_flush = rst_n & exmem_flush_c;
    assign idex_hold   = rst_n & idex_hold_c;
    assign exmem_hold  = rst_n & exmem_hold_c;
    assign pc_src      = rst_n & pc_src_c;
    assign mem_err     = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic             stall_evt, flush_evt;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Events mirror the RUN priority order: busy beats branch beats load-use
    assign flush_evt = (state_q == ST_RUN) && !mem_busy && branch_taken;
    assign stall_evt = (state_q == ST_RUN) && !mem_busy && !branch_taken && load_use;

    // Saturating increment of both performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_evt && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers, cleared by reset
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl (MEM_TIMEOUT=4). Inputs change just after the
// falling edge; expected controls are queued then and compared at the rising edge.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 16;
`ifdef HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, idex_hold, exmem_hold, pc_src, mem_err}
    localparam logic [8:0] O_IDLE  = 9'b11_000_00_0_0;
    localparam logic [8:0] O_STALL = 9'b00_010_00_0_0;
    localparam logic [8:0] O_FLUSH = 9'b11_111_00_1_0;
    localparam logic [8:0] O_HOLD  = 9'b00_000_11_0_0;
    localparam logic [8:0] O_ERR   = 9'b00_000_11_0_1;

    // {mem_busy, exmem_branch, exmem_zero, idex_memread, idex_rt, id_rs, id_rt}
    localparam logic [18:0] S_IDLE  = 19'd0;
    localparam logic [18:0] S_LU    = {4'b0001, 5'd5, 5'd5, 5'd0};
    localparam logic [18:0] S_LU2   = {4'b0001, 5'd7, 5'd1, 5'd7};
    localparam logic [18:0] S_BR    = {4'b0110, 5'd0, 5'd0, 5'd0};
    localparam logic [18:0] S_BRLU  = {4'b0111, 5'd5, 5'd5, 5'd0};
    localparam logic [18:0] S_NZLU  = {4'b0101, 5'd5, 5'd5, 5'd0};
    localparam logic [18:0] S_BUSY  = {4'b1000, 5'd0, 5'd0, 5'd0};
    localparam logic [18:0] S_BUSYX = {4'b1111, 5'd5, 5'd5, 5'd0};
    localparam logic [18:0] S_R0    = {4'b0001, 5'd0, 5'd0, 5'd0};
    localparam logic [18:0] S_NOMR  = {4'b0000, 5'd5, 5'd5, 5'd5};
    localparam logic [18:0] S_MISS  = {4'b0001, 5'd5, 5'd6, 5'd4};

    logic             clk;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, idex_rt;
    logic             idex_memread, exmem_branch, exmem_zero, mem_busy;
    logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
    logic             idex_hold, exmem_hold, pc_src, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [8:0]       outv;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb [$];

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
        .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .idex_hold(idex_hold), .exmem_hold(exmem_hold),
        .pc_src(pc_src), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign outv = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
                   idex_hold, exmem_hold, pc_src, mem_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_inputs(input logic [18:0] s);
        {mem_busy, exmem_branch, exmem_zero, idex_memread, idex_rt, id_rs, id_rt} = s;
    endtask

    // One pipeline cycle: drive after the falling edge, queue the expectation,
    // then stop at the rising edge where the Mealy outputs are sampled.
    task automatic drive(input logic [18:0] s, input logic [8:0] e);
        @(negedge clk);
        #1;
        set_inputs(s);
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        set_inputs(S_IDLE);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        rst_n = 1'b0;
        set_inputs(S_BRLU);
        #1;
        e = O_IDLE;
        checks++;
        $display("reset branch+loaduse out=%b", outv);
        if (outv !== e) begin errors++; $display("FAIL reset_idle_outputs got %b required %b", outv, e); end
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            errors++; $display("FAIL reset_counters got %0d/%0d required 0/0", stall_cnt, flush_cnt);
        end
        set_inputs(S_BUSYX);
        @(negedge clk);
        #1;
        checks++;
        $display("reset busy out=%b", outv);
        if (outv !== e) begin errors++; $display("FAIL reset_busy_idle got %b required %b", outv, e); end
        set_inputs(S_IDLE);
        #1;
        rst_n = 1'b1;
        drive(S_IDLE, O_IDLE);
        e = sb.pop_front();
        checks++;
        $display("reset release out=%b", outv);
        if (outv !== e) begin errors++; $display("FAIL reset_release got %b required %b", outv, e); end
    endtask

    task automatic test_load_use();
        logic [18:0] st [$];
        logic [8:0]  ex [$];
        logic [8:0]  e;
        st = '{S_LU, S_IDLE, S_LU2, S_IDLE, S_IDLE};
        ex = '{O_STALL, O_IDLE, O_STALL, O_IDLE, O_IDLE};
        apply_reset();
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            e = sb.pop_front();
            checks++;
            $display("load_use step %0d out=%b", i, outv);
            if (outv !== e) begin errors++; $display("FAIL load_use step %0d got %b required %b", i, outv, e); end
            if (i == 1) begin
                checks++;
                if (stall_cnt !== CNT_W'(PERF)) begin
                    errors++; $display("FAIL load_use_stall_cnt1 got %0d required %0d", stall_cnt, PERF);
                end
            end
        end
        checks++;
        if (stall_cnt !== CNT_W'(2 * PERF) || flush_cnt !== '0) begin
            errors++; $display("FAIL load_use_counters got %0d/%0d required %0d/0", stall_cnt, flush_cnt, 2 * PERF);
        end
    endtask

    task automatic test_no_hazard();
        logic [18:0] st [$];
        logic [8:0]  e;
        st = '{S_R0, S_NOMR, S_MISS, S_IDLE};
        apply_reset();
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], O_IDLE);
            e = sb.pop_front();
            checks++;
            $display("no_hazard step %0d out=%b", i, outv);
            if (outv !== e) begin errors++; $display("FAIL no_hazard step %0d got %b required %b", i, outv, e); end
        end
        checks++;
        if (stall_cnt !== '0) begin errors++; $display("FAIL no_hazard_stall_cnt got %0d required 0", stall_cnt); end
    endtask

    task automatic test_branch_priority();
        logic [18:0] st [$];
        logic [8:0]  ex [$];
        logic [8:0]  e;
        st = '{S_BRLU, S_IDLE};
        ex = '{O_FLUSH, O_IDLE};
        apply_reset();
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            e = sb.pop_front();
            checks++;
            $display("branch_priority step %0d out=%b", i, outv);
            if (outv !== e) begin errors++; $display("FAIL branch_priority step %0d got %b required %b", i, outv, e); end
        end
        checks++;
        if (flush_cnt !== CNT_W'(PERF) || stall_cnt !== '0) begin
            errors++; $display("FAIL branch_priority_counters got %0d/%0d required %0d/0", flush_cnt, stall_cnt, PERF);
        end
        // Branch without zero flag is not taken, so the load-use stall applies
        drive(S_NZLU, O_STALL);
        e = sb.pop_front();
        checks++;
        $display("branch_not_taken out=%b", outv);
        if (outv !== e) begin errors++; $display("FAIL branch_not_taken got %b required %b", outv, e); end
    endtask

    task automatic test_back_to_back();
        logic [18:0] st [$];
        logic [8:0]  ex [$];
        logic [8:0]  e;
        st = '{S_LU, S_LU2, S_BR, S_BRLU, S_LU, S_IDLE};
        ex = '{O_STALL, O_STALL, O_FLUSH, O_FLUSH, O_STALL, O_IDLE};
        apply_reset();
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            e = sb.pop_front();
            checks++;
            $display("back_to_back step %0d out=%b", i, outv);
            if (outv !== e) begin errors++; $display("FAIL back_to_back step %0d got %b required %b", i, outv, e); end
        end
        checks++;
        if (stall_cnt !== CNT_W'(3 * PERF) || flush_cnt !== CNT_W'(2 * PERF)) begin
            errors++; $display("FAIL back_to_back_counters got %0d/%0d required %0d/%0d",
                               stall_cnt, flush_cnt, 3 * PERF, 2 * PERF);
        end
    endtask

    task automatic test_mem_hold();
        logic [18:0] st [$];
        logic [8:0]  ex [$];
        logic [8:0]  e;
        // 3 busy cycles with hazards ignored, release cycle idle, then
        // exactly MEM_TIMEOUT busy cycles which must not fault
        st = '{S_BUSYX, S_BUSY, S_BUSYX, S_BRLU, S_BR, S_IDLE,
               S_BUSY, S_BUSY, S_BUSY, S_BUSY, S_IDLE, S_IDLE};
        ex = '{O_HOLD, O_HOLD, O_HOLD, O_IDLE, O_FLUSH, O_IDLE,
               O_HOLD, O_HOLD, O_HOLD, O_HOLD, O_IDLE, O_IDLE};
        apply_reset();
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            e = sb.pop_front();
            checks++;
            $display("mem_hold step %0d out=%b", i, outv);
            if (outv !== e) begin errors++; $display("FAIL mem_hold step %0d got %b required %b", i, outv, e); end
        end
        checks++;
        if (flush_cnt !== CNT_W'(PERF) || stall_cnt !== '0) begin
            errors++; $display("FAIL mem_hold_counters got %0d/%0d required %0d/0", flush_cnt, stall_cnt, PERF);
        end
    endtask

    task automatic test_timeout();
        logic [18:0] st [$];
        logic [8:0]  ex [$];
        logic [8:0]  e;
        st = '{S_BUSY, S_BUSY, S_BUSY, S_BUSY, S_BUSY, S_IDLE, S_BUSY, S_BRLU};
        ex = '{O_HOLD, O_HOLD, O_HOLD, O_HOLD, O_HOLD, O_ERR, O_ERR, O_ERR};
        apply_reset();
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            e = sb.pop_front();
            checks++;
            $display("timeout step %0d out=%b", i, outv);
            if (outv !== e) begin errors++; $display("FAIL timeout step %0d got %b required %b", i, outv, e); end
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        e = O_IDLE;
        checks++;
        $display("timeout in reset out=%b", outv);
        if (outv !== e) begin errors++; $display("FAIL timeout_reset_idle got %b required %b", outv, e); end
        set_inputs(S_IDLE);
        #1;
        rst_n = 1'b1;
        drive(S_BR, O_FLUSH);
        e = sb.pop_front();
        checks++;
        $display("timeout after reset out=%b", outv);
        if (outv !== e) begin errors++; $display("FAIL timeout_after_reset got %b required %b", outv, e); end
    endtask

    task automatic test_reset_in_hold();
        logic [18:0] st [$];
        logic [8:0]  ex [$];
        logic [8:0]  e;
        st = '{S_LU, S_BR, S_BUSY, S_BUSY};
        ex = '{O_STALL, O_FLUSH, O_HOLD, O_HOLD};
        apply_reset();
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            e = sb.pop_front();
            checks++;
            $display("reset_in_hold step %0d out=%b", i, outv);
            if (outv !== e) begin errors++; $display("FAIL reset_in_hold step %0d got %b required %b", i, outv, e); end
        end
        // Second HOLD cycle: pulse reset with memory still busy
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        e = O_IDLE;
        checks++;
        $display("reset_in_hold pulse out=%b", outv);
        if (outv !== e) begin errors++; $display("FAIL reset_in_hold_idle got %b required %b", outv, e); end
        set_inputs(S_IDLE);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        $display("reset_in_hold release out=%b", outv);
        if (outv !== e) begin errors++; $display("FAIL reset_in_hold_release got %b required %b", outv, e); end
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            errors++; $display("FAIL reset_in_hold_counters got %0d/%0d required 0/0", stall_cnt, flush_cnt);
        end
        // A fresh hold must again last MEM_TIMEOUT+1 busy cycles before the fault
        st = '{S_BUSY, S_BUSY, S_BUSY, S_BUSY, S_BUSY, S_IDLE};
        ex = '{O_HOLD, O_HOLD, O_HOLD, O_HOLD, O_HOLD, O_ERR};
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            e = sb.pop_front();
            checks++;
            $display("reset_in_hold rehold step %0d out=%b", i, outv);
            if (outv !== e) begin errors++; $display("FAIL reset_in_hold_rehold step %0d got %b required %b", i, outv, e); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_inputs(S_IDLE);
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_priority();
        test_back_to_back();
        test_mem_hold();
        test_timeout();
        test_reset_in_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before the end of the sequence");
        $fatal(1);
    end

endmodule
